// File: rtl/beep_sequencer.sv
// -----------------------------------------------------------------------------
// beep_sequencer
//   Buzzer pattern generator. Derives N_TONES square-wave tones from the system
//   clock (tone code k runs at BASE_HZ << (k-1), code 0 and codes above N_TONES
//   are silent) and plays a requested pattern of 1..15 beeps with programmable
//   on and off lengths, measured in units of UNIT_CYC clock cycles.
//
//   Optional feature: define BEEP_ABORT_EN to add the 'abort' input, which
//   returns the sequencer to IDLE from any active state without pulsing done.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Rst        in   asynchronous active-high reset
//   req        in   start request (ignored while busy)
//   tone       in   tone code, captured with req
//   beeps      in   number of beeps (0 = just pulse done), captured with req
//   on_units   in   beep length in units (0 is treated as 1), captured with req
//   off_units  in   gap length in units (0 = gapless), captured with req
//   abort      in   (BEEP_ABORT_EN only) cancel the running pattern
//   busy       out  high while a pattern is in progress, FIN cycle included
//   done       out  one-cycle pulse when a pattern completes
//   BuFreq     out  registered square wave to the buzzer
// -----------------------------------------------------------------------------
module beep_sequencer #(
  parameter int CLK_HZ   = 50000000,
  parameter int BASE_HZ  = 500,
  parameter int N_TONES  = 3,
  parameter int TONE_W   = 2,
  parameter int UNIT_CYC = 2500000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req,
  input  logic [TONE_W-1:0] tone,
  input  logic [3:0]        beeps,
  input  logic [7:0]        on_units,
  input  logic [7:0]        off_units,
`ifdef BEEP_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              BuFreq
);

  // Largest half period belongs to tone code 1.
  localparam int HALF_MAX = (CLK_HZ / (2 * BASE_HZ) < 1) ? 1 : CLK_HZ / (2 * BASE_HZ);
  localparam int HW       = $clog2(HALF_MAX + 1);
  localparam int CNT_W    = $clog2(UNIT_CYC * 255);

  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;

  // Half period in cycles for a tone code; 0 marks a silent code.
  function automatic int half_of(input logic [TONE_W-1:0] code);
    int h;
    if (code == '0 || int'(code) > N_TONES) return 0;
    h = CLK_HZ / (2 * (BASE_HZ << (int'(code) - 1)));
    return (h < 1) ? 1 : h;
  endfunction

  state_t            state_q, state_d;
  logic [HW-1:0]     half_q, half_d;          // captured half period, 0 = rest
  logic [3:0]        left_q, left_d;          // beeps still to play
  logic [CNT_W-1:0]  on_len_q, on_len_d;      // ON length minus one
  logic [CNT_W-1:0]  off_len_q, off_len_d;    // OFF length minus one
  logic              gapless_q, gapless_d;    // off_units was zero
  logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d; // cycles left in phase minus one
  logic [HW-1:0]     tone_cnt_q, tone_cnt_d;
  logic              buf_q, buf_d;
  logic              zero_done_q, zero_done_d; // done pulse for a beeps=0 request

  logic              abort_w;
  logic [HW-1:0]     cap_half;
  logic [CNT_W-1:0]  cap_on_len;
  logic [CNT_W-1:0]  cap_off_len;
  logic              audible;

`ifdef BEEP_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Derived forms of the request fields, stored at capture time so the
  // running pattern never looks at the live inputs again.
  assign cap_half    = HW'(half_of(tone));
  assign cap_on_len  = CNT_W'(((on_units == 8'd0) ? 1 : int'(on_units)) * UNIT_CYC - 1);
  assign cap_off_len = (off_units == 8'd0) ? '0 : CNT_W'(int'(off_units) * UNIT_CYC - 1);
  assign audible     = (half_q != '0);

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    left_d      = left_q;
    on_len_d    = on_len_q;
    off_len_d   = off_len_q;
    gapless_d   = gapless_q;
    phase_cnt_d = phase_cnt_q;
    tone_cnt_d  = tone_cnt_q;
    buf_d       = buf_q;
    zero_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        buf_d = 1'b0;
        if (req && !abort_w) begin
          half_d    = cap_half;
          left_d    = beeps;
          on_len_d  = cap_on_len;
          off_len_d = cap_off_len;
          gapless_d = (off_units == 8'd0);
          if (beeps == 4'd0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d     = ON;
            phase_cnt_d = cap_on_len;
            tone_cnt_d  = '0;
            buf_d       = (cap_half != '0);
          end
        end
      end
      ON: begin
        if (phase_cnt_q == '0) begin
          left_d = left_q - 4'd1;
          if (left_q == 4'd1) begin
            state_d = FIN;
            buf_d   = 1'b0;
          end else if (!gapless_q) begin
            state_d     = OFF;
            phase_cnt_d = off_len_q;
            buf_d       = 1'b0;
          end else begin
            // Back-to-back beep: tone phase restarts high.
            phase_cnt_d = on_len_q;
            tone_cnt_d  = '0;
            buf_d       = audible;
          end
        end else begin
          phase_cnt_d = phase_cnt_q - CNT_W'(1);
          if (audible) begin
            if (tone_cnt_q == half_q - HW'(1)) begin
              tone_cnt_d = '0;
              buf_d      = ~buf_q;
            end else begin
              tone_cnt_d = tone_cnt_q + HW'(1);
            end
          end
        end
      end
      OFF: begin
        buf_d = 1'b0;
        if (phase_cnt_q == '0) begin
          state_d     = ON;
          phase_cnt_d = on_len_q;
          tone_cnt_d  = '0;
          buf_d       = audible;
        end else begin
          phase_cnt_d = phase_cnt_q - CNT_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        buf_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (abort_w && state_q != IDLE) begin
      state_d = IDLE;
      buf_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      half_q      <= '0;
      left_q      <= '0;
      on_len_q    <= '0;
      off_len_q   <= '0;
      gapless_q   <= 1'b0;
      phase_cnt_q <= '0;
      tone_cnt_q  <= '0;
      buf_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      left_q      <= left_d;
      on_len_q    <= on_len_d;
      off_len_q   <= off_len_d;
      gapless_q   <= gapless_d;
      phase_cnt_q <= phase_cnt_d;
      tone_cnt_q  <= tone_cnt_d;
      buf_q       <= buf_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN) || zero_done_q;
  assign BuFreq = buf_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beep_sequencer
//   Scoreboard bench for beep_sequencer. Each accepted request pushes the
//   complete expected per-cycle trace of {busy, done, BuFreq}, built from the
//   pattern rules with plain loops and arithmetic. A monitor pops one entry per
//   cycle on the falling edge and expects all-zero outputs when nothing is
//   queued.
// -----------------------------------------------------------------------------
module tb_beep_sequencer;

  localparam int CLK_HZ   = 16000;
  localparam int BASE_HZ  = 500;
  localparam int N_TONES  = 3;
  localparam int TONE_W   = 2;
  localparam int UNIT_CYC = 64;
  localparam int BUDGET   = 5000;

  logic              Clk;
  logic              Rst;
  logic              req;
  logic [TONE_W-1:0] tone;
  logic [3:0]        beeps;
  logic [7:0]        on_units;
  logic [7:0]        off_units;
`ifdef BEEP_ABORT_EN
  logic              abort;
`endif
  logic              busy;
  logic              done;
  logic              BuFreq;

  beep_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .BASE_HZ (BASE_HZ),
    .N_TONES (N_TONES),
    .TONE_W  (TONE_W),
    .UNIT_CYC(UNIT_CYC)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .req      (req),
    .tone     (tone),
    .beeps    (beeps),
    .on_units (on_units),
    .off_units(off_units),
`ifdef BEEP_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .BuFreq   (BuFreq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Expected {busy, done, BuFreq} for each upcoming cycle.
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: expected trace of a request, from the pattern rules.
  task automatic push_model(input int t, input int b, input int on, input int off);
    int half;
    int on_c;
    logic bufv;
    if (b == 0) begin
      exp_q.push_back(3'b010);
      return;
    end
    if (t == 0 || t > N_TONES) half = 0;
    else begin
      half = CLK_HZ / (2 * (BASE_HZ << (t - 1)));
      if (half < 1) half = 1;
    end
    on_c = ((on == 0) ? 1 : on) * UNIT_CYC;
    for (int k = 0; k < b; k++) begin
      for (int c = 0; c < on_c; c++) begin
        bufv = (half != 0) && (((c / half) % 2) == 0);
        exp_q.push_back({1'b1, 1'b0, bufv});
      end
      if (k < b - 1)
        for (int c = 0; c < off * UNIT_CYC; c++) exp_q.push_back(3'b100);
    end
    exp_q.push_back(3'b110);
  endtask

  // Monitor: one comparison per cycle, away from the active edge.
  initial begin
    logic [2:0] exp;
    forever begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
      check("busy_done_bufreq", {29'd0, busy, done, BuFreq}, {29'd0, exp});
    end
  end

  // Returns at negedge+1 of the cycle whose expectation emptied the queue.
  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (n >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL wait_empty: %0d entries still queued after %0d cycles", exp_q.size(), BUDGET);
      exp_q.delete();
    end
  endtask

  task automatic scramble_inputs();
    tone      = TONE_W'($urandom);
    beeps     = 4'($urandom);
    on_units  = 8'($urandom);
    off_units = 8'($urandom);
  endtask

  // Issue a request from an IDLE cycle, then change the inputs to garbage.
  task automatic start(input int t, input int b, input int on, input int off);
    wait_empty();
    @(negedge Clk);
    #1;
    tone      = TONE_W'(t);
    beeps     = 4'(b);
    on_units  = 8'(on);
    off_units = 8'(off);
    req       = 1'b1;
    push_model(t, b, on, off);
    @(negedge Clk);
    #1;
    req = 1'b0;
    scramble_inputs();
  endtask

  initial begin
    Rst = 1'b0;
    req = 1'b0;
    tone = '0;
    beeps = '0;
    on_units = '0;
    off_units = '0;
`ifdef BEEP_ABORT_EN
    abort = 1'b0;
`endif
    #2 Rst = 1'b1;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bufreq", {31'd0, BuFreq}, 32'd0);
    repeat (2) @(negedge Clk);
    #1 Rst = 1'b0;
    repeat (2) @(negedge Clk);

    // Two beeps of code 1 with a one-unit gap; mid-pattern requests ignored.
    start(1, 2, 2, 1);
    repeat (40) @(negedge Clk);
    #1;
    req = 1'b1;
    scramble_inputs();
    @(negedge Clk);
    #1;
    req = 1'b0;
    repeat (100) @(negedge Clk);
    #1;
    req = 1'b1;
    scramble_inputs();
    @(negedge Clk);
    #1;
    req = 1'b0;

    // on_units=0 behaves as one unit; then a zero-beep request.
    start(3, 1, 0, 2);
    start(2, 0, 3, 3);

    // Silent beeps, then gapless audible beeps.
    start(0, 3, 1, 0);
    start(2, 3, 1, 0);

    // Request on the FIN cycle is ignored, the next cycle's is accepted.
    start(1, 1, 1, 1);
    wait_empty();
    tone = 2'd3;
    beeps = 4'd2;
    on_units = 8'd1;
    off_units = 8'd1;
    req = 1'b1;
    @(negedge Clk);
    #1;
    tone = 2'd2;
    beeps = 4'd1;
    on_units = 8'd2;
    off_units = 8'd0;
    push_model(2, 1, 2, 0);
    @(negedge Clk);
    #1;
    req = 1'b0;

    // Asynchronous reset during ON.
    start(2, 3, 2, 1);
    repeat (30) @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_bufreq", {31'd0, BuFreq}, 32'd0);
    exp_q.delete();
    @(negedge Clk);
    #1 Rst = 1'b0;
    repeat (4) @(negedge Clk);

`ifdef BEEP_ABORT_EN
    // Abort during the OFF phase of a five-beep pattern, then abort with req.
    start(1, 5, 1, 2);
    repeat (80) @(negedge Clk);
    #1;
    abort = 1'b1;
    exp_q.delete();
    @(negedge Clk);
    #1;
    req = 1'b1;
    tone = 2'd1;
    beeps = 4'd2;
    on_units = 8'd1;
    off_units = 8'd1;
    @(negedge Clk);
    #1;
    abort = 1'b0;
    req = 1'b0;
    repeat (4) @(negedge Clk);
`endif

    // Randomised patterns with occasional ignored requests while busy.
    for (int i = 0; i < 16; i++) begin
      start(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1 && exp_q.size() > 20) begin
        repeat (int'($urandom_range(1, 15))) @(negedge Clk);
        #1;
        req = 1'b1;
        scramble_inputs();
        @(negedge Clk);
        #1;
        req = 1'b0;
      end
    end

    wait_empty();
    repeat (4) @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beep_sequencer.md
Name: beep_sequencer

Overview:
- Parametrised buzzer pattern generator that replaces the fixed three-tone mux on BuFreq.
- Derives N_TONES square-wave tones from the system clock: tone code k has frequency BASE_HZ<<(k-1); code 0 is silence.
- Plays a requested pattern of 1..15 beeps, each with programmable on and off time. Sits between the FSM and the buzzer pin.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BASE_HZ, 500, frequency of tone code 1; each higher code doubles it.
- N_TONES, 3, number of audible tones; codes 1..N_TONES are valid.
- TONE_W, 2, width of the tone code; must satisfy 2^TONE_W > N_TONES.
- UNIT_CYC, 2500000, clock cycles per timing unit (50 ms at default CLK_HZ).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous active-high reset.
- req  input  1  start request, sampled on rising edge of Clk.
- tone  input  TONE_W  tone code, captured with req.
- beeps  input  4  number of beeps, captured with req.
- on_units  input  8  beep length in units, captured with req.
- off_units  input  8  gap length in units, captured with req.
- busy  output  1  high while a pattern is in progress.
- done  output  1  one-cycle pulse when a pattern completes.
- BuFreq  output  1  registered square wave to the buzzer.

Behaviour:
- Reset (async, any time, including mid-pattern): state IDLE; busy=0, done=0, BuFreq=0; all counters and captured fields cleared.
- Half period of code k: HALF(k) = CLK_HZ / (2*(BASE_HZ<<(k-1))), integer division, minimum 1.
- Codes above N_TONES are treated as silence.
- States:
  - IDLE: busy=0. On req=1, capture tone/beeps/on_units/off_units.
    - If beeps=0: stay IDLE and pulse done the next cycle.
    - Otherwise go to ON at that edge; busy=1 from the next cycle.
  - ON: lasts exactly max(on_units,1)*UNIT_CYC cycles.
    - BuFreq=1 on the first ON cycle if the tone is audible, then toggles every HALF(tone) cycles.
    - At the end, decrement the remaining-beep count.
    - If the count reaches 0, go to FIN. Else go to OFF if off_units≠0, or directly to ON if off_units=0; the tone phase restarts in each case.
  - OFF: BuFreq=0 for off_units*UNIT_CYC cycles, then ON. No OFF phase follows the last beep.
  - FIN: single cycle; done=1, BuFreq=0, busy=0 on the following cycle; next state IDLE.
- BuFreq is forced 0 in IDLE, OFF and FIN, and throughout ON when the tone is silent; the timing still runs, giving a rest.
- The unit timer and tone counter restart on every phase entry, so there is no carry-over between phases.
- req while busy=1 is ignored.
- Input changes while busy are ignored; only the captured copies are used.
- req on the FIN cycle is ignored; a new request is accepted from the first IDLE cycle.
- Counter widths: sized by $clog2 of UNIT_CYC*255 and max HALF; no wrap within legal ranges.
- Total pattern length in cycles: beeps*on*UNIT_CYC + (beeps-1)*off*UNIT_CYC + 1 (FIN).

Optional Feature:
- BEEP_ABORT_EN defined: adds input port abort (1 bit).
  - abort=1 in any non-IDLE state forces IDLE at the next edge, with BuFreq=0 and busy=0 from the next cycle.
  - done is not pulsed.
  - abort has priority over req when both are high in IDLE; req is then ignored.
- BEEP_ABORT_EN undefined: no abort port; every pattern runs to completion unless Rst is asserted.

Test Plan:
- Config for all tests: CLK_HZ=16000, BASE_HZ=500, N_TONES=3, UNIT_CYC=64, giving HALF = 16, 8, 4 for codes 1, 2, 3.
- Tone/beep count: req with tone=1, beeps=2, on=2, off=1 -> BuFreq toggles every 16 cycles for 128 cycles, low for 64, toggles for 128, then done pulses once. busy is high for exactly 321 cycles.
- Edge inputs: tone=3, beeps=1, on=0 -> on treated as 1; 64 cycles of period-8 square wave; no OFF phase; done at cycle 65. Then beeps=0 -> done pulse the next cycle, BuFreq stays 0.
- Silence and gapless beeps: tone=0, beeps=3, on=1, off=0 -> BuFreq=0 throughout, busy for 193 cycles. tone=2, off=0 -> phase restarts at each beep boundary with no low gap.
- Ignored requests: req with different fields mid-pattern -> no effect on the running pattern; req on the FIN cycle ignored; req on the following cycle accepted.
- Reset mid-pattern: Rst pulse during ON -> BuFreq, busy and done go 0 immediately (asynchronously); no done pulse after release.
- Abort (with BEEP_ABORT_EN): abort during OFF of a 5-beep pattern -> IDLE next cycle, no done; abort held with req in IDLE -> stays IDLE.
